sort_9_stream_ctrl: RTL and testbench
=====================================

// Module: sort_9_stream_ctrl
// PURPOSE
//   Sequencer that feeds a 9-input sorting network from a word stream. It collects
//   up to 9 words per frame and presents them on a packed bus to an external sorter.
//   After the sorter latency it captures the sorted vector and streams it back out
//   in ascending order. Frames shorter than 9 (in_last early) are padded with
//   all-ones so only real elements are emitted. Single buffer: no frame overlap.
// PARAMETERS
//   DATA_W    32  element width (unsigned compare, matches sorter)
//   SORT_LAT  0   sorter pipeline latency in clk cycles (0 = combinational)
//   CNT_W     16  width of completed-frame counter
// PORTS
//   clk        in   1         single clock, all logic on posedge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         input word valid
//   in_ready   out  1         controller accepts input word
//   in_data    in   DATA_W    input element
//   in_last    in   1         final element of frame (forced at 9th beat regardless)
//   srt_in     out  9*DATA_W  to sorter; slot k = bits [k*DATA_W +: DATA_W]
//   srt_out    in   9*DATA_W  from sorter, slot 0 = smallest
//   out_valid  out  1         sorted word valid
//   out_ready  in   1         downstream accepts sorted word
//   out_data   out  DATA_W    sorted element
//   out_last   out  1         final sorted element of frame
//   busy       out  1         high in WAIT or DRAIN
//   frame_cnt  out  CNT_W     completed frames, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async assert, sync release): state=FILL, idx=0, cnt=0, in_ready=1 after
//     release, out_valid=0, out_last=0, out_data=0, busy=0, frame_cnt=0,
//     all srt_in slots = all-ones. Reset mid-frame discards the frame; no partial output.
//   FILL: in_ready=1. Beat = in_valid&&in_ready writes slot idx, idx++.
//     Beat with in_last=1 or idx==8 ends frame: cnt=idx+1; slots cnt..8 set all-ones
//     in the same edge; next state WAIT. in_last is ignored unless it arrives with a beat.
//   WAIT: in_ready=0, busy=1, srt_in held stable. Lasts exactly SORT_LAT+1 cycles
//     (down-counter). On final WAIT edge srt_out is captured into result regs, idx=0,
//     next state DRAIN.
//   DRAIN: out_valid=1, out_data=result[idx], out_last=(idx==cnt-1). Handshake =
//     out_valid&&out_ready advances idx. out_data/out_last stable while stalled.
//     Handshake with out_last: frame_cnt++, idx=0, state FILL (in_ready=1 next cycle).
//   Latency: 9-word frame, out_ready=1, SORT_LAT=L: first out_valid L+1 cycles after
//     the 9th input beat edge; 9 output beats back-to-back.
//   Pads are all-ones so they sort above real data; real all-ones values are equal,
//     so emitting the first cnt slots is always correct. Ties: stable order not required.
//   in_ready and out_valid are never both high. srt_in changes only in FILL.
// TESTING
//   1 SORT_LAT=0, 9,3,7,1,8,2,6,4,5, out_ready=1 -> out 1..9, out_last on 9,
//     in_ready low from cycle after 9th beat until cycle after last out handshake.
//   2 Short frame 50,10,30 with in_last on 30 -> srt_in slots 3..8 = 32'hFFFF_FFFF;
//     exactly 3 out beats 10,30,50, out_last on 50, frame_cnt +1.
//   3 Backpressure: out_ready pattern 1,0,0,1,0,1... -> out_data/out_last held while
//     stalled; exactly 9 ascending beats, no drop/duplicate.
//   4 SORT_LAT=3 with delayed-model sorter -> capture exactly 4 cycles after WAIT
//     entry; srt_in unchanged throughout WAIT; in_valid pulses ignored (in_ready=0).
//   5 Reset asserted in DRAIN after 4 outputs -> out_valid=0 immediately, frame_cnt=0;
//     after release in_ready=1 and next frame 0,32'hFFFF_FFFF,5,5,2 sorts to
//     0,2,5,5,FFFF_FFFF with out_last on the 5th beat.
//   6 CNT_W=2, 5 single-word frames (in_last on first beat) -> each outputs 1 beat
//     with out_last=1; frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sort_9_stream_ctrl.sv
// Stream sequencer around an external 9-input sorting network: gathers a frame,
// waits out the sorter latency, then replays the sorted elements in ascending order.
module sort_9_stream_ctrl #(
    parameter int DATA_W   = 32,
    parameter int SORT_LAT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic [9*DATA_W-1:0]   srt_in,
    input  logic [9*DATA_W-1:0]   srt_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int WC_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;
    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          idx_q;
    logic [3:0]          cnt_q;
    logic [WC_W-1:0]     wait_q;
    logic [DATA_W-1:0]   slot_q [9];
    logic [DATA_W-1:0]   res_q  [9];
    logic                in_ready_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic                busy_q;
    logic [CNT_W-1:0]    frame_cnt_q;

    logic [3:0]          idx_inc_d;
    logic                beat_d;
    logic                frame_end_d;
    logic                hs_d;
    logic [DATA_W-1:0]   res_nxt_d;
    logic                last_nxt_d;

    // Handshake decode and look-ahead of the next element to present in DRAIN
    always_comb begin
        idx_inc_d   = idx_q + 4'd1;
        beat_d      = in_valid && in_ready_q && (state_q == ST_FILL);
        frame_end_d = beat_d && (in_last || (idx_q == 4'd8));
        hs_d        = out_valid_q && out_ready;
        last_nxt_d  = (idx_inc_d == (cnt_q - 4'd1));
        if (idx_inc_d < 4'd9) begin
            res_nxt_d = res_q[idx_inc_d];
        end else begin
            res_nxt_d = ONES;
        end
    end

    // Pack the staging slots onto the sorter input bus
    always_comb begin
        srt_in = {9*DATA_W{1'b0}};
        for (int k = 0; k < 9; k++) begin
            srt_in[k*DATA_W +: DATA_W] = slot_q[k];
        end
    end

    // Frame sequencer: FILL collects, WAIT covers sorter latency, DRAIN replays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            wait_q      <= {WC_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= {CNT_W{1'b0}};
            for (int k = 0; k < 9; k++) begin
                slot_q[k] <= ONES;
                res_q[k]  <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (beat_d) begin
                        slot_q[idx_q] <= in_data;
                        if (frame_end_d) begin
                            cnt_q <= idx_inc_d;
                            // Unused slots become all-ones so they sort to the top
                            for (int k = 0; k < 9; k++) begin
                                if (k > int'(idx_q)) begin
                                    slot_q[k] <= ONES;
                                end
                            end
                            state_q    <= ST_WAIT;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            wait_q     <= WC_W'(SORT_LAT);
                        end else begin
                            idx_q <= idx_inc_d;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_q == {WC_W{1'b0}}) begin
                        for (int k = 0; k < 9; k++) begin
                            res_q[k] <= srt_out[k*DATA_W +: DATA_W];
                        end
                        out_data_q  <= srt_out[DATA_W-1:0];
                        out_last_q  <= (cnt_q == 4'd1);
                        out_valid_q <= 1'b1;
                        idx_q       <= 4'd0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        wait_q <= wait_q - WC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (hs_d) begin
                        if (out_last_q) begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                            idx_q       <= 4'd0;
                            state_q     <= ST_FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            idx_q      <= idx_inc_d;
                            out_data_q <= res_nxt_d;
                            out_last_q <= last_nxt_d;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_FILL;
                    idx_q       <= 4'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sort_9_stream_ctrl.sv
// Bench for sort_9_stream_ctrl: three configurations share one stimulus path;
// a queue of expected sorted words is checked as the selected DUT drains.
module tb_sort_9_stream_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_last;
    logic         out_ready;
    logic [1:0]   sel;

    logic [287:0] srt_in0, srt_in3, srt_inc;
    logic [287:0] srt_out0, srt_out3, srt_outc;
    logic [287:0] st1, st2, st3;

    logic         ir0, ir3, irc, ov0, ov3, ovc, ol0, ol3, olc, bz0, bz3, bzc;
    logic [31:0]  od0, od3, odc;
    logic [15:0]  fc0, fc3;
    logic [1:0]   fcc;

    logic         in_ready_m, out_valid_m, out_last_m, busy_m;
    logic [31:0]  out_data_m;
    logic [15:0]  frame_cnt_m;
    logic [287:0] srt_in_m;

    int           n_checks;
    int           n_fail;
    int           pop_cnt;
    int           fc_exp [3];
    logic [32:0]  exp_q [$];
    bit           bp_en;
    bit           mon_en;

    function automatic logic [287:0] sort9(input logic [287:0] v);
        logic [31:0]  a [9];
        logic [31:0]  t;
        logic [287:0] r;
        for (int i = 0; i < 9; i++) a[i] = v[i*32 +: 32];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = a[i];
        return r;
    endfunction

    assign srt_out0 = sort9(srt_in0);
    assign srt_outc = sort9(srt_inc);
    assign srt_out3 = sort9(st3);

    always @(posedge clk) begin
        st1 <= srt_in3;
        st2 <= st1;
        st3 <= st2;
    end

    sort_9_stream_ctrl #(.DATA_W(32), .SORT_LAT(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd0)), .in_ready(ir0),
        .in_data(in_data), .in_last(in_last), .srt_in(srt_in0), .srt_out(srt_out0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
        .busy(bz0), .frame_cnt(fc0));

    sort_9_stream_ctrl #(.DATA_W(32), .SORT_LAT(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd1)), .in_ready(ir3),
        .in_data(in_data), .in_last(in_last), .srt_in(srt_in3), .srt_out(srt_out3),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_last(ol3),
        .busy(bz3), .frame_cnt(fc3));

    sort_9_stream_ctrl #(.DATA_W(32), .SORT_LAT(0), .CNT_W(2)) u_dutc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd2)), .in_ready(irc),
        .in_data(in_data), .in_last(in_last), .srt_in(srt_inc), .srt_out(srt_outc),
        .out_valid(ovc), .out_ready(out_ready), .out_data(odc), .out_last(olc),
        .busy(bzc), .frame_cnt(fcc));

    always_comb begin
        case (sel)
            2'd1: begin
                in_ready_m = ir3; out_valid_m = ov3; out_last_m = ol3; busy_m = bz3;
                out_data_m = od3; frame_cnt_m = fc3; srt_in_m = srt_in3;
            end
            2'd2: begin
                in_ready_m = irc; out_valid_m = ovc; out_last_m = olc; busy_m = bzc;
                out_data_m = odc; frame_cnt_m = {14'd0, fcc}; srt_in_m = srt_inc;
            end
            default: begin
                in_ready_m = ir0; out_valid_m = ov0; out_last_m = ol0; busy_m = bz0;
                out_data_m = od0; frame_cnt_m = fc0; srt_in_m = srt_in0;
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        automatic logic [2:0] pat = 3'd0;
        automatic logic [5:0] pattern = 6'b101001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = pattern[pat];
                pat = (pat == 3'd5) ? 3'd0 : pat + 3'd1;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: peek while stalled (hold check), pop on handshake
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check_val("ready_valid_exclusive", 288'(in_ready_m && out_valid_m), 288'(0));
            if (out_valid_m) begin
                if (exp_q.size() == 0) begin
                    check_val("beat_with_empty_queue", 288'(out_valid_m), 288'(0));
                end else begin
                    check_val("out_data", 288'(out_data_m), 288'(exp_q[0][31:0]));
                    check_val("out_last", 288'(out_last_m), 288'(exp_q[0][32]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", 288'(out_valid_m), 288'(0));
        check_val("rst_frame_cnt", 288'(frame_cnt_m), 288'(0));
        exp_q.delete();
        for (int i = 0; i < 3; i++) fc_exp[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 288'(in_ready_m), 288'(1));
        check_val("rst_busy", 288'(busy_m), 288'(0));
        check_val("rst_out_last", 288'(out_last_m), 288'(0));
        check_val("rst_out_data", 288'(out_data_m), 288'(0));
        check_val("rst_srt_in", srt_in_m, {288{1'b1}});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] w [9], input int n, input int lat,
                              input bit junk, input bit wait_done);
        logic [287:0] pad;
        logic [287:0] srt;
        int cyc;
        pop_cnt = 0;
        for (int i = 0; i < 9; i++) pad[i*32 +: 32] = (i < n) ? w[i] : 32'hFFFF_FFFF;
        srt = sort9(pad);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), srt[i*32 +: 32]});
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = (i == n - 1);
            cyc = 0;
            while (!in_ready_m && cyc < 100) begin
                @(posedge clk); #1; cyc++;
            end
            check_val("in_ready_timeout", 288'(in_ready_m), 288'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val("in_ready_low_after_last_beat", 288'(in_ready_m), 288'(0));
        check_val("busy_in_wait", 288'(busy_m), 288'(1));
        check_val("srt_in_padded", srt_in_m, pad);
        cyc = 0;
        while (!out_valid_m && cyc < 50) begin
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 32'h0BAD_0000 + 32'(cyc);
            end
            @(posedge clk); #1; cyc++;
            check_val("srt_in_stable", srt_in_m, pad);
            check_val("in_ready_low_wait", 288'(in_ready_m), 288'(0));
        end
        in_valid = 1'b0;
        check_val("first_out_latency", 288'(cyc), 288'(lat + 1));
        if (wait_done) begin
            cyc = 0;
            while ((exp_q.size() != 0 || !in_ready_m) && cyc < 300) begin
                @(posedge clk); #1; cyc++;
            end
            check_val("frame_done_in_ready", 288'(in_ready_m), 288'(1));
            check_val("frame_done_busy", 288'(busy_m), 288'(0));
            check_val("beat_count", 288'(pop_cnt), 288'(n));
            fc_exp[sel] = fc_exp[sel] + 1;
            check_val("frame_cnt", 288'(frame_cnt_m),
                      288'((sel == 2'd2) ? (fc_exp[sel] & 3) : (fc_exp[sel] & 16'hFFFF)));
        end
    endtask

    initial begin
        logic [31:0] w [9];
        int cyc;
        n_checks = 0; n_fail = 0; pop_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        sel = 2'd0; bp_en = 1'b0; mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        w = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4, 32'd5};
        send_frame(w, 9, 0, 1'b0, 1'b1);

        w = '{32'd50, 32'd10, 32'd30, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send_frame(w, 3, 0, 1'b0, 1'b1);

        bp_en = 1'b1;
        w = '{32'd20, 32'd90, 32'd40, 32'd70, 32'd10, 32'd80, 32'd30, 32'd60, 32'd50};
        send_frame(w, 9, 0, 1'b0, 1'b1);
        bp_en = 1'b0;

        sel = 2'd1;
        w = '{32'hDEAD_0001, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd77, 32'd12, 32'd12, 32'd3, 32'd1000};
        send_frame(w, 9, 3, 1'b1, 1'b1);

        sel = 2'd0;
        w = '{32'd15, 32'd14, 32'd13, 32'd12, 32'd11, 32'd10, 32'd9, 32'd8, 32'd7};
        send_frame(w, 9, 0, 1'b0, 1'b0);
        cyc = 0;
        while (pop_cnt < 4 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check_val("drain_four_beats", 288'(pop_cnt), 288'(4));
        do_reset();
        w = '{32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
        send_frame(w, 5, 0, 1'b0, 1'b1);

        sel = 2'd2;
        for (int f = 0; f < 5; f++) begin
            w = '{32'(100 + f), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
            send_frame(w, 1, 0, 1'b0, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
